// File: rtl/hour_counter.sv
// Hour stage of the alarm clock: 24h BCD hour with 12h view
// and day carry/borrow pulses toward a future date stage.
module hour_counter #(
    parameter int RESET_HOUR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       change_hour_up,
    input  logic       change_hour_down,
    input  logic       hour_up,
    input  logic       hour_down,
    output logic [3:0] right_hour,
    output logic [3:0] left_hour,
    output logic [3:0] right_hour12,
    output logic [3:0] left_hour12,
    output logic       pm,
    output logic       day_up,
    output logic       day_down
);

    localparam logic [3:0] RST_TENS = 4'(RESET_HOUR / 10);
    localparam logic [3:0] RST_ONES = 4'(RESET_HOUR % 10);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       prev_up_q, prev_up_d;
    logic       prev_dn_q, prev_dn_d;
    logic       day_up_q, day_up_d;
    logic       day_dn_q, day_dn_d;

    logic       cu, cd, inc, dec, illegal;
    logic [7:0] hour_bin;
    logic [7:0] hour12_bin;

    // Next hour, edge tracking and day pulses
    always_comb begin
        tens_d    = tens_q;
        ones_d    = ones_q;
        prev_up_d = change_hour_up;
        prev_dn_d = change_hour_down;
        day_up_d  = 1'b0;
        day_dn_d  = 1'b0;

        cu  = change_hour_up & ~prev_up_q;
        cd  = change_hour_down & ~prev_dn_q;
        inc = cu | hour_up;
        dec = cd | hour_down;

        illegal = (tens_q > 4'd2) || (ones_q > 4'd9) ||
                  ((tens_q == 4'd2) && (ones_q > 4'd3));

        // Opposing events in one cycle cancel out
        if (inc ^ dec) begin
            if (illegal) begin
                tens_d = 4'd0;
                ones_d = 4'd0;
            end else if (inc) begin
                if (tens_q == 4'd2 && ones_q == 4'd3) begin
                    tens_d   = 4'd0;
                    ones_d   = 4'd0;
                    day_up_d = cu;
                end else if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end else begin
                if (tens_q == 4'd0 && ones_q == 4'd0) begin
                    tens_d   = 4'd2;
                    ones_d   = 4'd3;
                    day_dn_d = cd;
                end else if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end
    end

    // State registers; edge detectors reload live levels on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q    <= RST_TENS;
            ones_q    <= RST_ONES;
            prev_up_q <= change_hour_up;
            prev_dn_q <= change_hour_down;
            day_up_q  <= 1'b0;
            day_dn_q  <= 1'b0;
        end else begin
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            prev_up_q <= prev_up_d;
            prev_dn_q <= prev_dn_d;
            day_up_q  <= day_up_d;
            day_dn_q  <= day_dn_d;
        end
    end

    // 12h display view derived from the stored 24h hour
    always_comb begin
        hour_bin = ({4'd0, tens_q} * 8'd10) + {4'd0, ones_q};
        pm       = (hour_bin >= 8'd12);
        if (hour_bin == 8'd0) begin
            hour12_bin = 8'd12;
        end else if (hour_bin > 8'd12) begin
            hour12_bin = hour_bin - 8'd12;
        end else begin
            hour12_bin = hour_bin;
        end
        if (hour12_bin >= 8'd10) begin
            left_hour12  = 4'd1;
            right_hour12 = 4'(hour12_bin - 8'd10);
        end else begin
            left_hour12  = 4'd0;
            right_hour12 = 4'(hour12_bin);
        end
    end

    assign right_hour = ones_q;
    assign left_hour  = tens_q;
    assign day_up     = day_up_q;
    assign day_down   = day_dn_q;

endmodule

// File: tb/tb_hour_counter.sv
// Bench for hour_counter: directed scenarios plus random traffic
// checked against an integer-hour reference model.
module tb_hour_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       change_hour_up = 1'b0;
    logic       change_hour_down = 1'b0;
    logic       hour_up = 1'b0;
    logic       hour_down = 1'b0;
    logic [3:0] right_hour, left_hour, right_hour12, left_hour12;
    logic       pm, day_up, day_down;

    int n_cmp = 0;
    int n_bad = 0;

    int m_h  = 0;
    int m_pu = 0;
    int m_pd = 0;
    int m_du = 0;
    int m_dd = 0;

    hour_counter #(.RESET_HOUR(0)) dut (
        .clk              (clk),
        .rst              (rst),
        .change_hour_up   (change_hour_up),
        .change_hour_down (change_hour_down),
        .hour_up          (hour_up),
        .hour_down        (hour_down),
        .right_hour       (right_hour),
        .left_hour        (left_hour),
        .right_hour12     (right_hour12),
        .left_hour12      (left_hour12),
        .pm               (pm),
        .day_up           (day_up),
        .day_down         (day_down)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: hour as a plain integer 0..23
    task automatic model(input int r, input int cu_l, input int cd_l,
                         input int hu, input int hd);
        int eu, ed, inc, dec;
        if (r != 0) begin
            m_h  = 0;
            m_du = 0;
            m_dd = 0;
        end else begin
            eu   = (cu_l != 0 && m_pu == 0) ? 1 : 0;
            ed   = (cd_l != 0 && m_pd == 0) ? 1 : 0;
            inc  = (eu != 0 || hu != 0) ? 1 : 0;
            dec  = (ed != 0 || hd != 0) ? 1 : 0;
            m_du = 0;
            m_dd = 0;
            if (inc == 1 && dec == 0) begin
                m_h = (m_h + 1) % 24;
                if (m_h == 0) m_du = eu;
            end else if (dec == 1 && inc == 0) begin
                m_h = (m_h + 23) % 24;
                if (m_h == 23) m_dd = ed;
            end
        end
        m_pu = cu_l;
        m_pd = cd_l;
    endtask

    task automatic check_all();
        int h12;
        h12 = (m_h % 12 == 0) ? 12 : m_h % 12;
        chk("hour24", int'(left_hour) * 10 + int'(right_hour), m_h);
        chk("tens24", int'(left_hour), m_h / 10);
        chk("hour12", int'(left_hour12) * 10 + int'(right_hour12), h12);
        chk("pm", int'(pm), (m_h >= 12) ? 1 : 0);
        chk("day_up", int'(day_up), m_du);
        chk("day_down", int'(day_down), m_dd);
    endtask

    task automatic step(input int r, input int cu_l, input int cd_l,
                        input int hu, input int hd);
        @(negedge clk);
        rst              = (r != 0);
        change_hour_up   = (cu_l != 0);
        change_hour_down = (cd_l != 0);
        hour_up          = (hu != 0);
        hour_down        = (hd != 0);
        model(r, cu_l, cd_l, hu, hd);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic go_to(input int h);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < h; i++) step(0, 0, 0, 1, 0);
    endtask

    initial begin
        // reset for two cycles
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_hour12", int'(left_hour12) * 10 + int'(right_hour12), 12);

        // 24 carry pulses walk the full day
        for (int i = 0; i < 24; i++) begin
            step(0, 1, 0, 0, 0);
            if (i == 23) chk("wrap_day_up", int'(day_up), 1);
            step(0, 0, 0, 0, 0);
        end

        // held carry counts once; three button presses
        go_to(7);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        chk("held_carry", int'(right_hour), 8);
        step(0, 0, 0, 0, 0);
        go_to(7);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        chk("three_ups", int'(left_hour) * 10 + int'(right_hour), 10);

        // manual wrap down: no pulse; borrow wrap: pulse
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("manual_wrap_dn", int'(day_down), 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("borrow_wrap_dn", int'(day_down), 1);
        step(0, 0, 0, 0, 0);

        // cancellation and coincident same-direction sources
        go_to(10);
        step(0, 0, 1, 1, 0);
        go_to(23);
        step(0, 1, 0, 1, 0);
        chk("coincident_up", int'(day_up), 1);
        step(0, 0, 0, 0, 0);

        // 12h map points
        go_to(13);
        go_to(12);
        go_to(11);

        // reset wins over a carry edge at 23
        go_to(23);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1 : 0,
                 ($urandom_range(0, 99) < 40) ? 1 : 0,
                 ($urandom_range(0, 99) < 40) ? 1 : 0,
                 ($urandom_range(0, 99) < 20) ? 1 : 0,
                 ($urandom_range(0, 99) < 20) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
